// File: rtl/quad_encoder_emulator.sv
// Quadrature encoder emulator: a phase accumulator turns a signed speed command
// into A/B/Z encoder edges plus a matching signed angle and revolution position.
module quad_encoder_emulator #(
  parameter int PERIOD_BITS = 25,
  parameter int MAX_MAG     = 2 ** (PERIOD_BITS - 2),
  parameter int CPR         = 2048
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic signed [31:0]      speed,
  output logic                    enc_a,
  output logic                    enc_b,
  output logic                    enc_z,
  output logic signed [31:0]      angle,
  output logic [$clog2(CPR)-1:0]  rev_pos,
  output logic                    step
);

  localparam int RW = $clog2(CPR);
  localparam logic [31:0]   MAX_MAG_W = 32'(MAX_MAG);
  localparam logic [RW-1:0] REV_LAST  = RW'(CPR - 1);

  // {enc_a, enc_b} is the state itself, so the FSM state is always observable.
  typedef enum logic [1:0] {
    Q_00 = 2'b00,
    Q_01 = 2'b01,
    Q_10 = 2'b10,
    Q_11 = 2'b11
  } quad_t;

  quad_t                  q, q_next;
  logic [PERIOD_BITS-1:0] acc, acc_next;
  logic signed [31:0]     angle_next;
  logic [RW-1:0]          rev_next;
  logic                   step_next;

  logic                   dir;
  logic [31:0]            speed_u;
  logic [31:0]            abs_speed;
  logic [PERIOD_BITS:0]   mag;
  logic [PERIOD_BITS:0]   sum;

  // Unsigned view makes |-2^31| come out as 2^31 before the clamp.
  assign dir       = speed[31];
  assign speed_u   = speed;
  assign abs_speed = dir ? (~speed_u + 32'd1) : speed_u;
  assign mag       = (abs_speed > MAX_MAG_W) ? MAX_MAG_W[PERIOD_BITS:0]
                                             : abs_speed[PERIOD_BITS:0];
  assign sum       = {1'b0, acc} + mag;

  always_comb begin
    acc_next   = acc;
    q_next     = q;
    angle_next = angle;
    rev_next   = rev_pos;
    step_next  = 1'b0;
    if (enable) begin
      acc_next = sum[PERIOD_BITS-1:0];
      if (sum[PERIOD_BITS]) begin
        step_next = 1'b1;
        if (!dir) begin
          angle_next = angle + 32'sd1;
          rev_next   = (rev_pos == REV_LAST) ? '0 : rev_pos + RW'(1);
          case (q)
            Q_00:    q_next = Q_10;
            Q_10:    q_next = Q_11;
            Q_11:    q_next = Q_01;
            default: q_next = Q_00;
          endcase
        end else begin
          angle_next = angle - 32'sd1;
          rev_next   = (rev_pos == '0) ? REV_LAST : rev_pos - RW'(1);
          case (q)
            Q_00:    q_next = Q_01;
            Q_01:    q_next = Q_11;
            Q_11:    q_next = Q_10;
            default: q_next = Q_00;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      q       <= Q_00;
      angle   <= '0;
      rev_pos <= '0;
      step    <= 1'b0;
    end else begin
      acc     <= acc_next;
      q       <= q_next;
      angle   <= angle_next;
      rev_pos <= rev_next;
      step    <= step_next;
    end
  end

  assign enc_a = q[1];
  assign enc_b = q[0];
  assign enc_z = (rev_pos == '0);

endmodule

// File: tb/tb_quad_encoder_emulator.sv
// Directed bench for quad_encoder_emulator: expected step events are queued by
// the stimulus and checked by a monitor on every step pulse.
module tb_quad_encoder_emulator;

  localparam int PB  = 4;
  localparam int MM  = 4;
  localparam int CPR = 8;
  localparam int EW  = 32 + 2 + 32 + 3;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b1;
  logic signed [31:0] speed = '0;
  logic               enc_a, enc_b, enc_z, step;
  logic signed [31:0] angle;
  logic [2:0]         rev_pos;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base;

  // Expected step event: {cycle, {a,b}, angle, rev_pos}.
  logic [EW-1:0] exp_q[$];

  quad_encoder_emulator #(.PERIOD_BITS(PB), .MAX_MAG(MM), .CPR(CPR)) dut (
    .clk(clk), .reset(reset), .enable(enable), .speed(speed),
    .enc_a(enc_a), .enc_b(enc_b), .enc_z(enc_z),
    .angle(angle), .rev_pos(rev_pos), .step(step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
    $fatal(1);
  end

  task automatic run(input int n, input logic signed [31:0] spd, input logic en);
    for (int i = 0; i < n; i++) begin
      speed  = spd;
      enable = en;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic signed [31:0] spd);
    reset = 1'b1;
    run(2, spd, 1'b1);
    reset = 1'b0;
  endtask

  task automatic push_exp(input int c, input logic [1:0] ab, input int ang, input int rev);
    logic [31:0] c_w;
    logic [31:0] a_w;
    logic [2:0]  r_w;
    c_w = c;
    a_w = ang;
    r_w = rev[2:0];
    exp_q.push_back({c_w, ab, a_w, r_w});
  endtask

  task automatic check_state(input string name, input logic [1:0] ab, input logic z,
                             input int ang, input int rev, input logic stp);
    logic [31:0] a_w;
    a_w = ang;
    tests++;
    if ({enc_a, enc_b} !== ab || enc_z !== z || angle !== a_w ||
        rev_pos !== rev[2:0] || step !== stp) begin
      fails++;
      $display("FAIL %s: got ab=%b z=%b angle=%0h rev=%0d step=%b, want ab=%b z=%b angle=%0h rev=%0d step=%b",
               name, {enc_a, enc_b}, enc_z, angle, rev_pos, step, ab, z, a_w, rev[2:0], stp);
    end
  endtask

  // Monitor: every step pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && step === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_step: cycle=%0d ab=%b angle=%0h rev=%0d, want no step",
                 cyc, {enc_a, enc_b}, angle, rev_pos);
      end else begin
        logic [EW-1:0] e;
        logic [31:0]   e_cyc;
        logic [1:0]    e_ab;
        logic [31:0]   e_ang;
        logic [2:0]    e_rev;
        logic [31:0]   cyc_w;
        e = exp_q.pop_front();
        {e_cyc, e_ab, e_ang, e_rev} = e;
        cyc_w = cyc;
        if (cyc_w !== e_cyc || {enc_a, enc_b} !== e_ab || angle !== e_ang ||
            rev_pos !== e_rev || enc_z !== (e_rev == 3'd0)) begin
          fails++;
          $display("FAIL step_event: got cyc=%0d ab=%b angle=%0h rev=%0d z=%b, want cyc=%0d ab=%b angle=%0h rev=%0d z=%b",
                   cyc, {enc_a, enc_b}, angle, rev_pos, enc_z,
                   e_cyc, e_ab, e_ang, e_rev, (e_rev == 3'd0));
        end
      end
    end
  end

  initial begin
    logic [1:0] rev_ab [4];
    rev_ab[0] = 2'b01; rev_ab[1] = 2'b11; rev_ab[2] = 2'b10; rev_ab[3] = 2'b00;

    // Reset with nonzero speed, then static with speed 0.
    do_reset(32'sd3);
    check_state("reset_values", 2'b00, 1'b1, 0, 0, 1'b0);
    run(6, 32'sd0, 1'b1);
    check_state("static_after_reset", 2'b00, 1'b1, 0, 0, 1'b0);

    // Forward, speed +2: a step every 8 cycles.
    do_reset(32'sd0);
    base = cyc;
    push_exp(base + 8,  2'b10, 1, 1);
    push_exp(base + 16, 2'b11, 2, 2);
    push_exp(base + 24, 2'b01, 3, 3);
    push_exp(base + 32, 2'b00, 4, 4);
    run(32, 32'sd2, 1'b1);
    check_state("forward_end", 2'b00, 1'b0, 4, 4, 1'b1);
    run(2, 32'sd0, 1'b1);

    // Reverse, speed -4: a step every 4 cycles, rev_pos wraps 0 -> 7.
    do_reset(32'sd0);
    base = cyc;
    for (int k = 1; k <= 8; k++)
      push_exp(base + 4 * k, rev_ab[(k - 1) % 4], -k, (8 - k) % 8);
    run(4, -32'sd4, 1'b1);
    check_state("reverse_first", 2'b01, 1'b0, -1, 7, 1'b1);
    run(28, -32'sd4, 1'b1);
    check_state("reverse_wrap", 2'b00, 1'b1, -8, 0, 1'b1);
    run(2, 32'sd0, 1'b1);

    // Clamp: 1000 and -2^31 both act as magnitude 4.
    do_reset(32'sd0);
    base = cyc;
    push_exp(base + 4,  2'b10, 1, 1);
    push_exp(base + 8,  2'b11, 2, 2);
    push_exp(base + 12, 2'b10, 1, 1);
    push_exp(base + 16, 2'b00, 0, 0);
    run(8, 32'sd1000, 1'b1);
    run(8, 32'sh8000_0000, 1'b1);
    check_state("clamp_end", 2'b00, 1'b1, 0, 0, 1'b1);
    run(2, 32'sd0, 1'b1);

    // Sign change across a freeze: residual phase 14 yields a step 1 cycle after resume.
    do_reset(32'sd0);
    base = cyc;
    push_exp(base + 6, 2'b10, 1, 1);
    run(10, 32'sd3, 1'b1);
    run(20, 32'sd3, 1'b0);
    check_state("frozen", 2'b10, 1'b0, 1, 1, 1'b0);
    push_exp(base + 31, 2'b00, 0, 0);
    run(1, -32'sd3, 1'b1);
    check_state("resume_step", 2'b00, 1'b1, 0, 0, 1'b1);
    run(4, 32'sd0, 1'b1);

    // Reset on the cycle a step is due.
    do_reset(32'sd0);
    base = cyc;
    push_exp(base + 4, 2'b10, 1, 1);
    run(7, 32'sd4, 1'b1);
    check_state("pre_reset", 2'b10, 1'b0, 1, 1, 1'b0);
    reset = 1'b1;
    run(1, 32'sd4, 1'b1);
    check_state("reset_mid_run", 2'b00, 1'b1, 0, 0, 1'b0);
    reset = 1'b0;
    run(4, 32'sd0, 1'b1);
    check_state("after_mid_reset", 2'b00, 1'b1, 0, 0, 1'b0);

    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_steps: %0d expected steps never seen, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
